axi_lite_rd_engine: RTL and testbench
=====================================

// Module: axi_lite_rd_engine
// PURPOSE
//  DMA read-side stage directly upstream of the DMA word FIFO. It accepts a
//  (source address, word count) command and issues single-beat AXI4-Lite
//  reads, one outstanding at a time. It pushes each OKAY beat into the FIFO
//  write port, then reports done/error to the DMA control FSM.
// PARAMETERS
//  ADDR_WIDTH  32  AXI address width; address arithmetic is modulo 2^ADDR_WIDTH
//  DATA_WIDTH  32  AXI data / FIFO word width; beat stride = DATA_WIDTH/8 bytes
//  LEN_WIDTH   16  word-count width; max transfer = 2^LEN_WIDTH-1 words
// PORTS
//  clk           in   1           clock, all logic on posedge
//  rst_n         in   1           reset, synchronous, active-low
//  cmd_valid     in   1           command request
//  cmd_ready     out  1           1 only in IDLE
//  cmd_addr      in   ADDR_WIDTH  source byte address (word aligned)
//  cmd_len       in   LEN_WIDTH   number of words
//  m_araddr      out  ADDR_WIDTH  AXI read address
//  m_arprot      out  3           constant 3'b000
//  m_arvalid     out  1           AXI address valid
//  m_arready     in   1           AXI address ready
//  m_rdata       in   DATA_WIDTH  AXI read data
//  m_rresp       in   2           AXI read response
//  m_rvalid      in   1           AXI read data valid
//  m_rready      out  1           AXI read data ready
//  fifo_w_en     out  1           FIFO write strobe
//  fifo_wdata    out  DATA_WIDTH  FIFO write data (= m_rdata)
//  fifo_full     in   1           FIFO full flag
//  busy          out  1           high in any state other than IDLE
//  done          out  1           one-cycle pulse at end of a command
//  err           out  1           sticky error, cleared on next accepted command
//  words_done    out  LEN_WIDTH   beats written to the FIFO for the current command
// BEHAVIOUR
//  Reset: state=IDLE; m_arvalid=0, m_rready=0, fifo_w_en=0, done=0, err=0,
//   busy=0, words_done=0, m_araddr=0. Reset mid-transfer drops to IDLE at
//   once; any outstanding beat is abandoned (system resets slave together).
//  FSM states: IDLE, ISSUE, ADDR, DATA, DONE.
//  IDLE: cmd_ready=1. On cmd_valid, latch addr and len, clear err and
//   words_done, and go to DONE if cmd_len==0, else to ISSUE.
//  ISSUE: if !fifo_full, go to ADDR (m_arvalid=1 next cycle); else wait.
//   The FIFO-full check is done here so no beat is ever fetched without space.
//  ADDR: m_arvalid=1, m_araddr stable; held until m_arready; then go to DATA.
//  DATA: m_rready=1. On m_rvalid:
//   - rresp==2'b00 (OKAY): fifo_w_en=m_rvalid&m_rready&OKAY (combinational,
//     same cycle). words_done++, remaining--, addr += DATA_WIDTH/8 (wraps).
//     Go to DONE if remaining was 1, else to ISSUE.
//   - rresp!=OKAY: no FIFO write, err<=1, go to DONE (abort remainder).
//  DONE: done=1 for exactly one cycle, then go to IDLE.
//  Timing: command accepted in cycle 0 -> ISSUE in 1 -> arvalid in 2 (FIFO
//   not full). Minimum 3 cycles per beat with zero-wait slave.
//  m_arvalid never drops before m_arready, even if fifo_full rises meanwhile.
//  cmd_valid outside IDLE is ignored (cmd_ready=0).
//  Address wrap: 0xFFFF_FFFC + 4 -> 0x0000_0000, with no error.
//  words_done saturates naturally at cmd_len; held after DONE until next cmd.
// STRUCTURE
//  Shared package dma_pkg: rd_state_t enum, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR,
//   AXI_PROT_DEFAULT, BYTES_PER_BEAT function of DATA_WIDTH.
//  No sub-module: one FSM always block, address/count registers, and
//   combinational FIFO strobe. Top-level DMA instantiates this module next to
//   fifo (fifo_w_en/fifo_wdata/fifo_full wired directly).
// TESTING
//  1: cmd addr=0x1000 len=4, zero-wait slave returning 0xA0..0xA3 -> araddr
//     0x1000,0x1004,0x1008,0x100C; 4 fifo_w_en pulses; done at the end;
//     words_done=4; err=0.
//  2: fifo_full held high 20 cycles after cmd -> arvalid stays 0 for 20 cycles;
//     first AR issues on the cycle after full deasserts.
//  3: arready delayed 5 cycles on beat 2, then fifo_full asserted -> arvalid and
//     araddr stay stable until handshake.
//  4: len=3, beat 2 rresp=SLVERR -> 1 FIFO write; done pulses; err=1;
//     words_done=1; next cmd clears err.
//  5: len=0 -> done two cycles after cmd handshake; no AR; err=0. Also
//     addr=0xFFFFFFF8 len=3 -> araddr ...F8,...FC,0x0.
//  6: rst_n low while in DATA -> next cycle IDLE, all outputs at reset values;
//     a fresh len=2 cmd then completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA definitions: read-engine state encoding and AXI4-Lite constants.
package dma_pkg;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_ISSUE = 3'd1,
        RD_ADDR  = 3'd2,
        RD_DATA  = 3'd3,
        RD_DONE  = 3'd4
    } rd_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Byte stride between consecutive single-beat reads.
    function automatic int unsigned bytes_per_beat(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axi_lite_rd_engine.sv
// DMA read engine: turns an (address, word count) command into a sequence of
// single-outstanding AXI4-Lite reads and streams OKAY beats into the word FIFO.
module axi_lite_rd_engine
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    // AXI4-Lite read master
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    // FIFO write port
    output logic                  fifo_w_en,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    input  logic                  fifo_full,
    // status
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  words_done
);

    localparam int unsigned           BEAT_BYTES  = bytes_per_beat(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(BEAT_BYTES);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE     = LEN_WIDTH'(1);

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]  words_done_q, words_done_d;
    logic                  err_q, err_d;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  busy_q;
    logic                  cmd_ready_q;
    logic                  done_q;

    logic                  beat_fire;
    logic                  beat_ok;

    // Read-data handshake and response classification for the current beat.
    assign beat_fire = rready_q & m_rvalid;
    assign beat_ok   = (m_rresp == AXI_RESP_OKAY);

    // Next-state, address and counter update for one command.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        err_d        = err_q;

        case (state_q)
            RD_IDLE: begin
                if (cmd_valid) begin
                    addr_d       = cmd_addr;
                    remaining_d  = cmd_len;
                    words_done_d = '0;
                    err_d        = 1'b0;
                    state_d      = (cmd_len == '0) ? RD_DONE : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                // Only fetch a beat once the FIFO has room for it.
                if (!fifo_full) begin
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                // arvalid is held regardless of fifo_full until accepted.
                if (m_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (beat_fire) begin
                    if (beat_ok) begin
                        words_done_d = words_done_q + LEN_ONE;
                        remaining_d  = remaining_q - LEN_ONE;
                        addr_d       = addr_q + ADDR_STRIDE;
                        state_d      = (remaining_q == LEN_ONE) ? RD_DONE : RD_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RD_DONE;
                    end
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RD_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            err_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            err_q        <= err_d;
            arvalid_q    <= (state_d == RD_ADDR);
            rready_q     <= (state_d == RD_DATA);
            busy_q       <= (state_d != RD_IDLE);
            cmd_ready_q  <= (state_d == RD_IDLE);
            done_q       <= (state_q == RD_DONE);
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign m_araddr   = addr_q;
    assign m_arprot   = AXI_PROT_DEFAULT;
    assign m_arvalid  = arvalid_q;
    assign m_rready   = rready_q;
    // FIFO strobe follows the accepted OKAY beat in the same cycle.
    assign fifo_w_en  = beat_fire & beat_ok;
    assign fifo_wdata = m_rdata;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_axi_lite_rd_engine.sv
// Scoreboard bench for axi_lite_rd_engine: a randomised AXI4-Lite slave model,
// expected AR addresses / FIFO words queued at command issue, and a monitor
// that pops and compares on every handshake.
module tb_axi_lite_rd_engine;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned LW     = 16;
    localparam int unsigned STRIDE = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] m_araddr;
    logic [2:0]    m_arprot;
    logic          m_arvalid;
    logic          m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rvalid;
    logic          m_rready;
    logic          fifo_w_en;
    logic [DW-1:0] fifo_wdata;
    logic          fifo_full;
    logic          busy;
    logic          done;
    logic          err;
    logic [LW-1:0] words_done;

    always #5 clk = ~clk;

    axi_lite_rd_engine #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .m_araddr  (m_araddr),
        .m_arprot  (m_arprot),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .fifo_w_en (fifo_w_en),
        .fifo_wdata(fifo_wdata),
        .fifo_full (fifo_full),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .words_done(words_done)
    );

    typedef struct {
        int          ar_dly;
        int          r_dly;
        logic [1:0]  resp;
        logic [DW-1:0] data;
    } beat_t;

    logic [AW-1:0] exp_ar_q[$];
    logic [DW-1:0] exp_w_q[$];
    beat_t         plan_q[$];

    int checks = 0;
    int errors = 0;

    bit rand_full = 1'b0;
    bit full_req  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the beats a command should produce, up to and including the first error.
    task automatic plan_cmd(input logic [AW-1:0] addr, input int len, input int err_beat,
                            input int slow_beat, input int slow_ar, input int slow_r,
                            input bit rnd, input logic [DW-1:0] data_base,
                            output int exp_words, output bit exp_err);
        beat_t b;
        exp_words = 0;
        exp_err   = 1'b0;
        for (int i = 0; i < len; i++) begin
            exp_ar_q.push_back(addr + AW'(i * STRIDE));
            b.ar_dly = rnd ? int'($urandom_range(0, 3)) : ((i == slow_beat) ? slow_ar : 0);
            b.r_dly  = rnd ? int'($urandom_range(0, 3)) : ((i == slow_beat) ? slow_r : 0);
            b.data   = (data_base != '0) ? data_base + DW'(i) : DW'($urandom);
            if (i == err_beat) begin
                b.resp = 2'($urandom_range(1, 3));
                plan_q.push_back(b);
                exp_err = 1'b1;
                break;
            end
            b.resp = 2'b00;
            plan_q.push_back(b);
            exp_w_q.push_back(b.data);
            exp_words++;
        end
    endtask

    task automatic clear_sb();
        exp_ar_q.delete();
        exp_w_q.delete();
        plan_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check({tag, "_arvalid"},  m_arvalid, 0);
        check({tag, "_rready"},   m_rready, 0);
        check({tag, "_fifo_wen"}, fifo_w_en, 0);
        check({tag, "_done"},     done, 0);
        check({tag, "_err"},      err, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_words"},    words_done, 0);
        check({tag, "_araddr"},   m_araddr, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_arprot"},   m_arprot, 0);
    endtask

    task automatic recover();
        rst_n = 1'b0;
        tick();
        tick();
        clear_sb();
        rst_n = 1'b1;
        tick();
    endtask

    // Presents a command at P+1; returns at the negedge after the accepting edge (+junk cycles).
    task automatic send_cmd(input logic [AW-1:0] addr, input int len, input int junk, output int elapsed);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = LW'(len);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        tick();
        if (junk > 0) begin
            cmd_addr = DW'($urandom) & 32'hFFFF_FFFC;
            cmd_len  = 16'hFFFF;
        end else begin
            cmd_valid = 1'b0;
        end
        @(negedge clk);
        check("accept_busy", busy, 1);
        check("accept_err_clr", err, 0);
        check("accept_words_clr", words_done, 0);
        check("accept_cmd_ready", cmd_ready, 0);
        elapsed = 0;
        for (int j = 0; j < junk; j++) begin
            @(negedge clk);
            elapsed++;
        end
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for done and checks the command's final status.
    task automatic finish_cmd(input int cyc0, input int ew, input bit ee, input int limit, input int exp_lat);
        int cyc;
        cyc = cyc0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < limit);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, expected a done pulse", cyc);
            recover();
            return;
        end
        if (exp_lat >= 0) check("done_latency", cyc, exp_lat);
        check("words_done", words_done, ew);
        check("err", err, ee);
        check("ar_outstanding", exp_ar_q.size(), 0);
        check("fifo_outstanding", exp_w_q.size(), 0);
        @(negedge clk);
        check("done_width", done, 0);
        check("idle_busy", busy, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("words_held", words_done, ew);
        check("err_held", err, ee);
        tick();
    endtask

    task automatic run_cmd(input logic [AW-1:0] addr, input int len, input int err_beat,
                           input int slow_beat, input int slow_ar, input int slow_r,
                           input bit rnd, input logic [DW-1:0] data_base, input int junk,
                           input int limit, input int exp_lat);
        int ew;
        bit ee;
        int el;
        plan_cmd(addr, len, err_beat, slow_beat, slow_ar, slow_r, rnd, data_base, ew, ee);
        send_cmd(addr, len, junk, el);
        finish_cmd(el, ew, ee, limit, exp_lat);
    endtask

    // FIFO-full driver: random back-pressure or the directed request.
    initial begin
        fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : full_req;
        end
    end

    // AXI4-Lite slave model: serves planned beats with their AR/R delays.
    beat_t cur;
    int    s_phase;
    int    s_cnt;
    initial begin
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        s_phase   = 0;
        s_cnt     = 0;
        forever begin
            tick();
            if (!rst_n) begin
                m_arready = 1'b0;
                m_rvalid  = 1'b0;
                s_phase   = 0;
            end else begin
                if (s_phase == 4) begin
                    m_rvalid = 1'b0;
                    s_phase  = 0;
                end
                if (s_phase == 2) begin
                    m_arready = 1'b0;
                    s_cnt     = cur.r_dly;
                    s_phase   = 3;
                end
                if (s_phase == 0 && m_arvalid) begin
                    if (plan_q.size() > 0) begin
                        cur = plan_q.pop_front();
                    end else begin
                        cur.ar_dly = 0;
                        cur.r_dly  = 0;
                        cur.resp   = 2'b00;
                        cur.data   = 32'hDEAD_BEEF;
                    end
                    s_cnt   = cur.ar_dly;
                    s_phase = 1;
                end
                if (s_phase == 1) begin
                    if (s_cnt == 0) begin
                        m_arready = 1'b1;
                        s_phase   = 2;
                    end else begin
                        s_cnt--;
                    end
                end
                if (s_phase == 3) begin
                    if (s_cnt == 0) begin
                        m_rvalid = 1'b1;
                        m_rdata  = cur.data;
                        m_rresp  = cur.resp;
                        s_phase  = 4;
                    end else begin
                        s_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: compares every AR and FIFO handshake against the expected queues.
    bit            prev_ar_wait = 1'b0;
    logic [AW-1:0] prev_araddr  = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ar_wait = 1'b0;
            end else begin
                if (prev_ar_wait) begin
                    check("ar_hold_valid", m_arvalid, 1);
                    check("ar_hold_addr", m_araddr, prev_araddr);
                end
                prev_ar_wait = m_arvalid && !m_arready;
                prev_araddr  = m_araddr;
                if (m_arvalid && m_arready) begin
                    if (exp_ar_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ar: got araddr 0x%0h, expected no read", m_araddr);
                    end else begin
                        check("ar_addr", m_araddr, exp_ar_q.pop_front());
                    end
                end
                if (fifo_w_en) begin
                    if (exp_w_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fifo_write: got 0x%0h, expected no write", fifo_wdata);
                    end else begin
                        check("fifo_wdata", fifo_wdata, exp_w_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: time limit reached, expected the stimulus to complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Stimulus: directed scenarios followed by randomised commands.
    initial begin
        int            ew;
        bit            ee;
        int            el;
        int            c;
        int            rises;
        bit            prev_v;
        bit            seen_ar;
        logic [AW-1:0] a;
        int            l;
        int            eb;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        repeat (3) tick();
        check_reset_vals("por");
        tick();
        rst_n = 1'b1;
        tick();

        // Four zero-wait beats with a command held on cmd_valid while busy.
        run_cmd(32'h0000_1000, 4, -1, -1, 0, 0, 1'b0, 32'hA0, 2, 200, 13);

        // FIFO full for 20 cycles after the command.
        plan_cmd(32'h0000_2000, 2, -1, -1, 0, 0, 1'b0, '0, ew, ee);
        full_req = 1'b1;
        send_cmd(32'h0000_2000, 2, 0, el);
        seen_ar = m_arvalid;
        repeat (19) begin
            @(negedge clk);
            seen_ar = seen_ar | m_arvalid;
        end
        check("full_blocks_ar", seen_ar, 0);
        tick();
        full_req = 1'b0;
        @(negedge clk);
        check("ar_before_release", m_arvalid, 0);
        @(negedge clk);
        check("ar_after_release", m_arvalid, 1);
        finish_cmd(0, ew, ee, 200, -1);

        // Slow arready on beat 2 with fifo_full rising while the address waits.
        plan_cmd(32'h0000_2400, 3, -1, 1, 5, 0, 1'b0, '0, ew, ee);
        send_cmd(32'h0000_2400, 3, 0, el);
        rises  = 0;
        prev_v = 1'b0;
        c      = 0;
        while (rises < 2 && c < 100) begin
            @(negedge clk);
            if (m_arvalid && !prev_v) rises++;
            prev_v = m_arvalid;
            c++;
        end
        check("second_ar_seen", rises, 2);
        tick();
        full_req = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("ar_held_under_full", m_arvalid, 1);
        check("araddr_held_under_full", m_araddr, 32'h0000_2404);
        repeat (6) tick();
        full_req = 1'b0;
        finish_cmd(0, ew, ee, 300, -1);

        // Slave error on the second of three beats, then a command that clears err.
        run_cmd(32'h0000_3000, 3, 1, -1, 0, 0, 1'b0, '0, 0, 200, 7);

        // Zero-length command and an address that wraps past the top.
        run_cmd(32'h0000_4000, 0, -1, -1, 0, 0, 1'b0, '0, 0, 50, 1);
        run_cmd(32'hFFFF_FFF8, 3, -1, -1, 0, 0, 1'b0, '0, 0, 200, 10);

        // Reset while waiting for read data, then a fresh command.
        plan_cmd(32'h0000_5000, 2, -1, 0, 0, 10, 1'b0, '0, ew, ee);
        send_cmd(32'h0000_5000, 2, 0, el);
        c = 0;
        while (!m_rready && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("reached_data", m_rready, 1);
        tick();
        rst_n = 1'b0;
        tick();
        clear_sb();
        check_reset_vals("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        run_cmd(32'h0000_6000, 2, -1, -1, 0, 0, 1'b0, '0, 0, 200, 7);

        // Randomised commands with random slave delays, errors and FIFO back-pressure.
        rand_full = 1'b1;
        for (int k = 0; k < 30; k++) begin
            a = AW'($urandom) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | (a & 32'h0000_000C);
            l  = int'($urandom_range(0, 6));
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_cmd(a, l, eb, -1, 0, 0, 1'b1, '0, 0, 600, -1);
        end
        rand_full = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
